// File: rtl/uart_rx_controller.sv
// ---------------------------------------------------------------------------
// uart_rx_controller
//
// Sequencing controller for a UART receiver datapath:
//   * synchronizes the raw serial line and detects the start (falling) edge,
//   * emits one-clock baud_rate_signal ticks positioned in the middle of each
//     bit (start, 8 data, stop) for the receiver to sample on,
//   * buffers the receiver's bytes in a small FIFO and hands them to a
//     downstream consumer over a valid/ready handshake, with a sticky
//     overrun flag for bytes dropped while the FIFO was full.
//
// Parameters
//   DIV_W        width of the baud divisor (clock cycles per bit)
//   FIFO_DEPTH   received-byte buffer entries (power of 2, >= 2)
//   SYNC_STAGES  flops in the uart_rx synchronizer (>= 2)
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous, active-high reset
//   enable            1 = active; 0 = stop ticking and return to IDLE
//   baud_div          clocks per bit, captured at the start-edge detect
//   uart_rx           raw serial line, idle high
//   baud_rate_signal  one-clock tick to the receiver, mid-bit aligned
//   rx_data           receiver data byte
//   rx_valid          receiver valid_data pulse (pushes rx_data)
//   m_data            FIFO head byte
//   m_valid           FIFO non-empty
//   m_ready           consumer accepts the head when m_valid & m_ready
//   overrun           sticky: a byte was dropped because the FIFO was full
//   clear_overrun     synchronous clear of overrun (and frame_err if built)
//   frame_err         sticky bad-stop-bit flag (only with RX_FRAME_ERR_EN)
//   busy              1 while the FSM is not IDLE
//
// Build option
//   RX_FRAME_ERR_EN   when defined, adds the frame_err output and checks
//                     the stop-bit level at the tenth tick of each frame.
// ---------------------------------------------------------------------------
module uart_rx_controller #(
    parameter int DIV_W       = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             uart_rx,
    output logic             baud_rate_signal,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             overrun,
    input  logic             clear_overrun,
`ifdef RX_FRAME_ERR_EN
    output logic             frame_err,
`endif
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    // -----------------------------------------------------------------------
    // Line synchronizer and start-edge detector
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   fall;

    // Flops reset to 1 so a line that is idle at reset release never looks
    // like a start edge.
    // NOTE: state is written with non-blocking (<=) assignments so every
    // flop samples the pre-edge value of its neighbours, which is what makes
    // this shift register a real chain of flops rather than a single wire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], uart_rx};
            rx_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_prev & ~rx_s;

    // -----------------------------------------------------------------------
    // Baud tick sequencer
    // -----------------------------------------------------------------------
    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] divider;
    logic [3:0]       bit_cnt;
    logic             tick_q;
    logic             at_tick;

    // A divisor below 2 cannot place a tick mid-bit, so it is clamped.
    assign div_eff = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;

    // The cycle in which the divider sits at zero is the tick cycle; the tick
    // flop is set on the edge that moves the divider from 1 to 0 so the
    // registered output lines up with that cycle exactly.
    assign at_tick = (state == FRAME) && (divider == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div_lat <= '0;
            divider <= '0;
            bit_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (!enable) begin
            // Abort immediately; a tick due on this edge is swallowed.
            state  <= IDLE;
            tick_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tick_q <= 1'b0;
                    if (fall) begin
                        // Half a bit to the middle of the start bit.
                        div_lat <= div_eff;
                        divider <= div_eff >> 1;
                        bit_cnt <= '0;
                        state   <= FRAME;
                    end
                end
                FRAME: begin
                    if (divider == '0) begin
                        // Tick cycle: bit_cnt still holds the number of
                        // earlier ticks, so 0 means this is the start bit
                        // and 9 means this is the stop bit.
                        tick_q  <= 1'b0;
                        divider <= div_lat - DIV_W'(1);
                        bit_cnt <= bit_cnt + 4'd1;
                        if ((bit_cnt == 4'd0) && rx_s) begin
                            state <= IDLE;      // line back high: glitch
                        end
                        if (bit_cnt == 4'd9) begin
                            state <= IDLE;      // stop bit reached
                        end
                    end else begin
                        divider <= divider - DIV_W'(1);
                        tick_q  <= (divider == DIV_W'(1));
                    end
                end
                default: begin
                    state  <= IDLE;
                    tick_q <= 1'b0;
                end
            endcase
        end
    end

    assign baud_rate_signal = tick_q;
    assign busy             = (state != IDLE);

`ifdef RX_FRAME_ERR_EN
    // -----------------------------------------------------------------------
    // Stop-bit check: a low line at the tenth tick flags a framing error.
    // The byte itself is still buffered by the normal push path.
    // -----------------------------------------------------------------------
    logic ferr_set;

    assign ferr_set = at_tick && (bit_cnt == 4'd9) && !rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (ferr_set) begin
            frame_err <= 1'b1;                  // set wins over clear
        end else if (clear_overrun) begin
            frame_err <= 1'b0;
        end
    end
`else
    logic unused_at_tick;
    assign unused_at_tick = at_tick;
`endif

    // -----------------------------------------------------------------------
    // Receive FIFO
    //   Pointers carry one extra wrap bit: equal pointers mean empty, equal
    //   low bits with differing wrap bits mean full.
    // -----------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] wptr_nxt;
    logic [AW:0] rptr_nxt;
    logic [7:0]  head_nxt;
    logic        full;
    logic        pop;
    logic        wr_en;
    logic        ovr_set;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = m_valid & m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still
    // accept the byte.
    assign wr_en   = rx_valid & (~full | pop);
    assign ovr_set = rx_valid & full & ~pop;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rptr_nxt = rptr;
        wptr_nxt = wptr;
        head_nxt = m_data;
        if (pop) begin
            rptr_nxt = rptr + PW'(1);
        end
        if (wr_en) begin
            wptr_nxt = wptr + PW'(1);
        end
        // The next head may be the slot being written right now (empty FIFO,
        // or a single entry popped while a new one arrives); take it from
        // rx_data since the array is only updated on the edge.
        if (wr_en && (wptr[AW-1:0] == rptr_nxt[AW-1:0])) begin
            head_nxt = rx_data;
        end else begin
            head_nxt = mem[rptr_nxt[AW-1:0]];
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and leaving it unreset lets it map onto plain
    // register-file or RAM cells.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= rx_data;
        end
    end

    // m_data is registered from the next-state head so it is glitch-free and
    // simply holds the last presented byte once the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            overrun <= 1'b0;
        end else begin
            wptr    <= wptr_nxt;
            rptr    <= rptr_nxt;
            m_valid <= (rptr_nxt != wptr_nxt);
            if (rptr_nxt != wptr_nxt) begin
                m_data <= head_nxt;
            end
            if (ovr_set) begin
                overrun <= 1'b1;                // set wins over clear
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
Sequencing controller for the UART receiver datapath. It synchronizes the raw serial line and detects the start edge. It generates the phase-aligned one-cycle baud_rate_signal ticks the receiver samples on, so each tick lands mid-bit. It collects the receiver's data/valid_data output into a small FIFO and presents it to a downstream consumer over a valid/ready handshake, with overrun tracking.

Parameters:
DIV_W, 16, width of the baud divisor (clock cycles per bit)
FIFO_DEPTH, 4, received-byte buffer entries; power of 2, minimum 2
SYNC_STAGES, 2, flops in the uart_rx synchronizer; minimum 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = controller active; 0 = stop ticking, return to IDLE
baud_div  input  DIV_W  clocks per bit; sampled only on the start-edge detect
uart_rx  input  1  raw serial line, idle high
baud_rate_signal  output  1  one-clk tick to receiver, mid-bit aligned
rx_data  input  8  receiver data
rx_valid  input  1  receiver valid_data pulse
m_data  output  8  FIFO head byte
m_valid  output  1  FIFO non-empty
m_ready  input  1  consumer accepts head when m_valid & m_ready
overrun  output  1  sticky: byte dropped because FIFO full
clear_overrun  input  1  synchronous clear of overrun (and frame_err if built)
busy  output  1  1 while FSM is not IDLE

Behaviour:
- Reset (async, rst=1): FSM=IDLE, divider=0, bit counter=0, FIFO empty, synchronizer flops=1.
- Reset outputs: baud_rate_signal=0, m_valid=0, m_data=0, overrun=0, busy=0.
- Synchronizer: uart_rx passes through SYNC_STAGES flops to give rx_s. A falling edge is rx_s=0 with the previous rx_s=1.
- Effective divisor: div_eff = max(baud_div, 2).
- FSM state IDLE:
  - No ticks are generated.
  - On a falling edge with enable=1: latch div_eff, load divider with div_eff>>1, clear bit counter, go to FRAME.
- FSM state FRAME:
  - Divider decrements each clk.
  - When divider reaches 0: baud_rate_signal=1 for exactly one clk, divider reloads div_eff-1, bit counter increments.
  - The first tick therefore falls half a bit after the edge (mid start bit).
  - False start: if rx_s=1 at tick 1, return to IDLE after that tick.
  - After tick 10 (start + 8 data + stop), go to IDLE.
  - An edge arriving while in FRAME is ignored.
- enable=0 in any state: go to IDLE next clk, any tick in flight is suppressed, FIFO contents are retained.
- Tick spacing: exactly div_eff clks between consecutive ticks of one frame.
- busy = (state != IDLE).
- FIFO push on rx_valid=1, in any FSM state.
  - Not full: write rx_data at the tail.
  - Full with no pop that cycle: byte is discarded and overrun is set to 1.
- FIFO pop on m_valid & m_ready.
  - Full with simultaneous push and pop: both proceed, no overrun.
  - Empty with push: the byte appears on m_data/m_valid on the next clk (1-clk latency). A pop cannot occur in the same cycle.
- m_data is always the head entry; m_data is 0 when empty after reset, otherwise holds the last value.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
  - Full: pointer MSBs differ and the lower bits are equal.
- overrun clears only on clear_overrun=1 or rst. If clear and a new overrun occur in the same clk, overrun stays set.

Optional Feature:
Macro RX_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0).
  - At tick 10, if rx_s=0 (bad stop bit), frame_err is set (sticky).
  - Cleared by clear_overrun under the same rules as overrun.
  - The byte is still buffered.
- Undefined: no frame_err port, stop-bit level is not checked, all other behaviour is identical.

Test Plan:
1. rst pulse, then idle line with enable=1, baud_div=8 -> baud_rate_signal stays 0, busy=0, m_valid=0, overrun=0.
2. baud_div=8, drive frame 0x41 (start, LSB-first bits, stop) at 8 clk/bit -> 10 ticks: first at 4 clks after the synchronized edge, then every 8 clks; busy drops after tick 10. Model receiver pulses rx_valid with rx_data=0x41 -> m_valid=1, m_data=0x41 next clk.
3. 2-clk low glitch on uart_rx, baud_div=8 -> exactly one tick, FSM back to IDLE, no further ticks.
4. m_ready=0, push 5 bytes 0x01..0x05 via rx_valid -> first 4 bytes buffered, overrun=1. Then m_ready=1 -> pops 0x01,0x02,0x03,0x04 in order, m_valid=0. Then clear_overrun -> overrun=0.
5. FIFO full with rx_valid and m_ready both high in the same clk -> no overrun, count stays 4, order preserved.
6. enable=0 at tick 5 of a frame -> ticks stop next clk, busy=0. With RX_FRAME_ERR_EN defined, a frame with stop bit 0 -> frame_err=1 after tick 10.
